// File: rtl/conv_pkg.sv
// Shared definitions for the FIR convolution MAC sequencer:
//   - state_e        : sequencer states (IDLE / MAC / OUT)
//   - DEF_* constants: default sample width, coefficient width and tap count
//   - calc_acc_w()   : accumulator width that can never overflow
//   - DEF_COEF_INIT  : default packed coefficient bank, h[k] at [k*COEF_W +: COEF_W]
package conv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    OUT  = 2'd2
  } state_e;

  localparam int unsigned DEF_DATA_W = 2;
  localparam int unsigned DEF_COEF_W = 2;
  localparam int unsigned DEF_NTAPS  = 4;

  // Sum of NTAPS products of DATA_W x COEF_W unsigned values.
  function automatic int unsigned calc_acc_w(input int unsigned dw,
                                             input int unsigned cw,
                                             input int unsigned nt);
    return dw + cw + $clog2(nt);
  endfunction

  // h = {0, 1, 3, 2} for k = 0..3
  localparam logic [DEF_NTAPS*DEF_COEF_W-1:0] DEF_COEF_INIT = 8'b10_11_01_00;

endpackage

// File: rtl/conv_mac_unit.sv
// Registered multiply-accumulate unit shared by all taps.
// Ports:
//   clk, rst  : clock and synchronous active-high reset
//   clr_i     : clear the accumulator (has priority over en_i)
//   en_i      : add a_i*b_i to the accumulator
//   a_i, b_i  : unsigned operands
//   acc_o     : accumulator value
module conv_mac_unit #(
  parameter int unsigned A_W   = 2,
  parameter int unsigned B_W   = 2,
  parameter int unsigned ACC_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [A_W-1:0]   a_i,
  input  logic [B_W-1:0]   b_i,
  output logic [ACC_W-1:0] acc_o
);

  logic [A_W+B_W-1:0] prod_s;
  logic [ACC_W-1:0]   acc_q;

  // Operands are zero-extended so the product keeps its full width.
  assign prod_s = {{B_W{1'b0}}, a_i} * {{A_W{1'b0}}, b_i};

  // Accumulator register.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
    end else if (clr_i) begin
      acc_q <= '0;
    end else if (en_i) begin
      acc_q <= acc_q + ACC_W'(prod_s);
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/conv_mac_sequencer.sv
// FIR convolution sequencer: one accepted sample produces one result by
// stepping a single MAC unit through all taps, one tap per cycle.
// Ports:
//   clk, rst                      : clock, synchronous active-high reset
//   in_valid/in_ready/in_data     : sample input handshake (accepted only in IDLE)
//   out_valid/out_ready/out_data  : result output handshake (held until taken)
//   flush                         : zero the delay line, honoured only in IDLE
//   busy                          : state is not IDLE
// Optional build macro CONV_COEF_LOAD_EN adds coef_wr/coef_addr/coef_data for
// writing coefficients while IDLE; without it the bank is the constant COEF_INIT.
module conv_mac_sequencer
  import conv_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned COEF_W = DEF_COEF_W,
  parameter int unsigned NTAPS  = DEF_NTAPS,
  parameter int unsigned ACC_W  = calc_acc_w(DATA_W, COEF_W, NTAPS),
  parameter logic [NTAPS*COEF_W-1:0] COEF_INIT = DEF_COEF_INIT
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_W-1:0]          in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [ACC_W-1:0]           out_data,
  input  logic                       flush,
`ifdef CONV_COEF_LOAD_EN
  input  logic                       coef_wr,
  input  logic [$clog2(NTAPS)-1:0]   coef_addr,
  input  logic [COEF_W-1:0]          coef_data,
`endif
  output logic                       busy
);

  // Tap counter runs 0..NTAPS; the extra step lets the last product land in
  // the accumulator before it is copied to out_data.
  localparam int unsigned K_W   = $clog2(NTAPS + 1);
  localparam int unsigned IDX_W = $clog2(NTAPS);

  state_e             state_q;
  logic [K_W-1:0]     tap_q;
  logic               out_valid_q;
  logic               busy_q;
  logic [ACC_W-1:0]   out_data_q;
  logic [DATA_W-1:0]  x_q [NTAPS];
  logic [COEF_W-1:0]  h_q [NTAPS];
  logic [DATA_W-1:0]  sel_x_s;
  logic [COEF_W-1:0]  sel_h_s;
  logic [ACC_W-1:0]   acc_s;
  logic               mac_clr_s;
  logic               mac_en_s;

`ifdef CONV_COEF_LOAD_EN
  logic [COEF_W-1:0]  h_d [NTAPS];

  // Coefficient writes only take effect in IDLE so a running sum never sees a change.
  always_comb begin
    for (int k = 0; k < NTAPS; k++) begin
      h_d[k] = (coef_wr && (state_q == IDLE) && (coef_addr == IDX_W'(k))) ? coef_data : h_q[k];
    end
  end

  // Coefficient bank register.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NTAPS; k++) h_q[k] <= COEF_INIT[k*COEF_W +: COEF_W];
    end else begin
      for (int k = 0; k < NTAPS; k++) h_q[k] <= h_d[k];
    end
  end
`else
  // Constant coefficient bank.
  always_comb begin
    for (int k = 0; k < NTAPS; k++) h_q[k] = COEF_INIT[k*COEF_W +: COEF_W];
  end
`endif

  // AND-OR select of the current tap's sample and coefficient (zero when tap_q == NTAPS).
  always_comb begin
    sel_x_s = '0;
    sel_h_s = '0;
    for (int k = 0; k < NTAPS; k++) begin
      sel_x_s = sel_x_s | (x_q[k] & {DATA_W{tap_q == K_W'(k)}});
      sel_h_s = sel_h_s | (h_q[k] & {COEF_W{tap_q == K_W'(k)}});
    end
  end

  assign mac_clr_s = (state_q == IDLE) && in_valid;
  assign mac_en_s  = (state_q == MAC) && (tap_q != K_W'(NTAPS));

  conv_mac_unit #(
    .A_W   (COEF_W),
    .B_W   (DATA_W),
    .ACC_W (ACC_W)
  ) u_mac (
    .clk   (clk),
    .rst   (rst),
    .clr_i (mac_clr_s),
    .en_i  (mac_en_s),
    .a_i   (sel_h_s),
    .b_i   (sel_x_s),
    .acc_o (acc_s)
  );

  // Sequencer FSM, delay line and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      tap_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      busy_q      <= 1'b0;
      for (int k = 0; k < NTAPS; k++) x_q[k] <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            // With flush the older taps are cleared and only the new sample survives.
            x_q[0] <= in_data;
            for (int k = 1; k < NTAPS; k++) x_q[k] <= flush ? '0 : x_q[k-1];
            tap_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= MAC;
          end else if (flush) begin
            for (int k = 0; k < NTAPS; k++) x_q[k] <= '0;
          end
        end
        MAC: begin
          if (tap_q == K_W'(NTAPS)) begin
            out_data_q  <= acc_s;
            out_valid_q <= 1'b1;
            state_q     <= OUT;
          end else begin
            tap_q <= tap_q + K_W'(1);
          end
        end
        OUT: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q     <= IDLE;
          tap_q       <= '0;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_conv_mac_sequencer.sv
module tb_conv_mac_sequencer;

  localparam int NT = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [5:0] out_data;
  logic       flush;
  logic       busy;
`ifdef CONV_COEF_LOAD_EN
  logic       coef_wr;
  logic [1:0] coef_addr;
  logic [1:0] coef_data;
`endif

  int total = 0;
  int bad   = 0;

  // Reference model: sample history (newest first) and coefficient bank.
  int hist [NT];
  int coef [NT];

  typedef struct {
    int d;
    bit fl;
    int exp;
  } vec_t;

  always #5 clk = ~clk;

  conv_mac_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .flush     (flush),
`ifdef CONV_COEF_LOAD_EN
    .coef_wr   (coef_wr),
    .coef_addr (coef_addr),
    .coef_data (coef_data),
`endif
    .busy      (busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  function automatic void model_reset();
    foreach (hist[k]) hist[k] = 0;
    coef[0] = 0; coef[1] = 1; coef[2] = 3; coef[3] = 2;
  endfunction

  function automatic int model_accept(input int d, input bit fl);
    int s = 0;
    if (fl) foreach (hist[k]) hist[k] = 0;
    for (int k = NT - 1; k > 0; k--) hist[k] = hist[k-1];
    hist[0] = d;
    foreach (hist[k]) s += coef[k] * hist[k];
    return s;
  endfunction

  // One transaction starting and ending on a negedge with the DUT idle.
  // stall: cycles of forced out_ready=0 (with unconsumed offers) once the result is up.
  // noisy: randomise inputs that must be ignored while busy.
  task automatic xact(input int d, input bit fl, input bit noisy, input int stall,
                      input string tag, output int got);
    int exp, lat, n;
    bit done, hs;
    logic [5:0] held;
    check({tag, ".in_ready"}, in_ready, 1);
    in_valid = 1'b1; in_data = 2'(d); flush = fl;
    exp = model_accept(d, fl);
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0; flush = 1'b0;
`ifdef CONV_COEF_LOAD_EN
    coef_wr = 1'b0;
`endif
    lat = 0;
    while (out_valid !== 1'b1 && lat < 40) begin
      if (noisy) begin
        in_valid = 1'($urandom); in_data = 2'($urandom); flush = 1'($urandom);
        out_ready = 1'($urandom);
`ifdef CONV_COEF_LOAD_EN
        coef_wr = 1'($urandom); coef_addr = 2'($urandom); coef_data = 2'($urandom);
`endif
      end
      @(posedge clk); @(negedge clk);
      lat++;
    end
    check({tag, ".latency"}, lat, NT + 1);
    check({tag, ".data"}, out_data, exp);
    check({tag, ".busy"}, busy, 1);
    got = out_data;
    held = out_data;
    n = 0; done = 1'b0;
    while (!done && n < 60) begin
      if (n < stall) begin
        out_ready = 1'b0; in_valid = 1'b1; in_data = 2'($urandom);
        check({tag, ".stall_in_ready"}, in_ready, 0);
      end else if (noisy && n < 30) begin
        out_ready = 1'($urandom); in_valid = 1'($urandom);
        in_data = 2'($urandom); flush = 1'($urandom);
`ifdef CONV_COEF_LOAD_EN
        coef_wr = 1'($urandom); coef_addr = 2'($urandom); coef_data = 2'($urandom);
`endif
      end else begin
        out_ready = 1'b1;
      end
      hs = out_ready;
      @(posedge clk); @(negedge clk);
      n++;
      if (hs) begin
        done = 1'b1;
      end else begin
        check({tag, ".hold_valid"}, out_valid, 1);
        check({tag, ".hold_data"}, out_data, held);
      end
    end
    if (!done) begin
      total++; bad++;
      $display("FAIL %s.handshake: got timeout want handshake", tag);
    end
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
`ifdef CONV_COEF_LOAD_EN
    coef_wr = 1'b0;
`endif
    check({tag, ".post_valid"}, out_valid, 0);
    check({tag, ".post_in_ready"}, in_ready, 1);
  endtask

  task automatic flush_idle();
    flush = 1'b1;
    @(posedge clk); @(negedge clk);
    flush = 1'b0;
    foreach (hist[k]) hist[k] = 0;
  endtask

`ifdef CONV_COEF_LOAD_EN
  task automatic wr_coef(input int a, input int v);
    coef_wr = 1'b1; coef_addr = 2'(a); coef_data = 2'(v);
    @(posedge clk); @(negedge clk);
    coef_wr = 1'b0;
    coef[a] = v;
  endtask
`endif

  initial begin
    vec_t imp [8];
    int   dimp [8] = '{0, 1, 2, 1, 0, 0, 0, 0};
    int   yimp [8] = '{0, 0, 1, 5, 9, 7, 2, 0};
    int   got, vseen, expmax;

    foreach (imp[i]) begin
      imp[i].d = dimp[i]; imp[i].fl = 1'b0; imp[i].exp = yimp[i];
    end

    rst = 1'b1; in_valid = 1'b0; in_data = 2'd0; out_ready = 1'b1; flush = 1'b0;
`ifdef CONV_COEF_LOAD_EN
    coef_wr = 1'b0; coef_addr = 2'd0; coef_data = 2'd0;
`endif
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("reset.in_ready", in_ready, 1);
    check("reset.out_valid", out_valid, 0);
    check("reset.out_data", out_data, 0);
    check("reset.busy", busy, 0);

    // Impulse response from the table.
    for (int i = 0; i < 8; i++) begin
      xact(imp[i].d, imp[i].fl, 1'b0, 0, $sformatf("imp%0d", i), got);
      check($sformatf("imp%0d.table", i), got, imp[i].exp);
    end

    // Backpressure: ten stalled cycles with offered samples that must be ignored.
    xact(3, 1'b0, 1'b0, 10, "bp", got);
    xact(1, 1'b0, 1'b0, 0, "bp_after", got);

    // Maximum inputs.
`ifdef CONV_COEF_LOAD_EN
    for (int k = 0; k < NT; k++) wr_coef(k, 3);
    expmax = 36;
`else
    expmax = 18;
`endif
    for (int i = 0; i < 4; i++) xact(3, i == 0, 1'b0, 0, $sformatf("max%0d", i), got);
    check("max.value", got, expmax);

    // Reset two cycles after an accept.
    in_valid = 1'b1; in_data = 2'd2;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    model_reset();
    check("rstmac.in_ready", in_ready, 1);
    check("rstmac.busy", busy, 0);
    vseen = 0;
    repeat (8) begin
      if (out_valid !== 1'b0) vseen++;
      @(posedge clk); @(negedge clk);
    end
    check("rstmac.no_valid", vseen, 0);
    xact(1, 1'b0, 1'b0, 0, "rstmac_next", got);
    check("rstmac.result", got, 0);

    // Flush alone in IDLE, then flush together with a sample.
    xact(1, 1'b0, 1'b0, 0, "fl_a", got);
    xact(2, 1'b0, 1'b0, 0, "fl_b", got);
    flush_idle();
    xact(1, 1'b0, 1'b0, 0, "fl_c", got);
    check("flush.first", got, 0);
    xact(0, 1'b0, 1'b0, 0, "fl_d", got);
    check("flush.second", got, 1);
    xact(3, 1'b1, 1'b0, 0, "fl_e", got);
    check("flush_load.first", got, 0);
    xact(1, 1'b0, 1'b0, 0, "fl_f", got);
    check("flush_load.second", got, 3);

    // Random traffic with noise on ignored inputs.
    for (int i = 0; i < 40; i++) begin
      xact(int'($urandom_range(0, 3)), ($urandom_range(0, 4) == 0), 1'b1,
           int'($urandom_range(0, 3)), $sformatf("rnd%0d", i), got);
    end

`ifdef CONV_COEF_LOAD_EN
    // Coefficient writes: IDLE write lands, writes while busy are dropped.
    wr_coef(0, 2);
    xact(1, 1'b1, 1'b0, 0, "cw_a", got);
    check("coef.idle_write", got, 2);
    xact(1, 1'b1, 1'b1, 0, "cw_b", got);
    check("coef.busy_write_dropped", got, 2);
    coef_wr = 1'b1; coef_addr = 2'd1; coef_data = 2'd3;
    coef[1] = 3;
    xact(1, 1'b0, 1'b0, 0, "cw_c", got);
    check("coef.write_with_sample", got, 5);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
